period_meter: RTL

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// Measures the sigIn rising-edge period in clockIn cycles, with a sticky no-edge timeout.
// Optional 4-period averaging is enabled by defining PERIOD_METER_AVG_EN.
module period_meter #(
  parameter int unsigned TIMEOUT = 100000000,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             clockIn,
  input  logic             rst,
  input  logic             sigIn,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t            state, stateNext;
  logic              sync1, sync2, prev;
  logic              sigEdge;
  logic [WIDTH-1:0]  cnt, cntNext;
  logic [WIDTH-1:0]  periodNext;
  logic              validNext, lockedNext, timeoutNext;

`ifdef PERIOD_METER_AVG_EN
  logic [WIDTH+1:0]  acc, accNext, captureSum;
  logic [1:0]        idx, idxNext;

  assign captureSum = acc + (WIDTH+2)'(cnt) + (WIDTH+2)'(1);
`endif

  // Two-flop synchronizer plus a history flop for rising-edge detection
  always_ff @(negedge clockIn or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sigIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sigEdge = sync2 & ~prev;

  always_ff @(negedge clockIn or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      acc          <= '0;
      idx          <= '0;
`endif
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      period_out   <= periodNext;
      period_valid <= validNext;
      locked       <= lockedNext;
      timeout      <= timeoutNext;
`ifdef PERIOD_METER_AVG_EN
      acc          <= accNext;
      idx          <= idxNext;
`endif
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    periodNext  = period_out;
    validNext   = 1'b0;
    lockedNext  = locked;
    timeoutNext = timeout;
`ifdef PERIOD_METER_AVG_EN
    accNext     = acc;
    idxNext     = idx;
`endif
    case (state)
      IDLE: begin
        cntNext = '0;
        if (sigEdge) stateNext = MEASURE;
      end
      MEASURE: begin
        // An edge coinciding with expiry still completes the period
        if (sigEdge) begin
          cntNext     = '0;
          timeoutNext = 1'b0;
`ifdef PERIOD_METER_AVG_EN
          if (idx == 2'd3) begin
            periodNext = WIDTH'(captureSum >> 2);
            validNext  = 1'b1;
            lockedNext = 1'b1;
            accNext    = '0;
            idxNext    = '0;
          end else begin
            accNext = captureSum;
            idxNext = idx + 2'd1;
          end
`else
          periodNext = cnt + WIDTH'(1);
          validNext  = 1'b1;
          lockedNext = 1'b1;
`endif
        end else if (cnt == CNT_LAST) begin
          stateNext   = IDLE;
          cntNext     = '0;
          timeoutNext = 1'b1;
          lockedNext  = 1'b0;
`ifdef PERIOD_METER_AVG_EN
          accNext     = '0;
          idxNext     = '0;
`endif
        end else begin
          cntNext = cnt + WIDTH'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
